// File: rtl/wb_multi_port_if.sv
// Channel-side and regfile-side bus of the write-back stage.
// The master modport is the producer/consumer view; the slave modport is the stage itself.
interface wb_multi_port_if #(
    parameter int NUM_CH    = 3,
    parameter int NUM_WP    = 1,
    parameter int TAG_WIDTH = 4,
    parameter int XLEN      = 32
);
    logic [NUM_CH-1:0]           ch_valid;
    logic [NUM_CH-1:0]           ch_ready;
    logic [NUM_CH*TAG_WIDTH-1:0] ch_tag;
    logic [NUM_CH*5-1:0]         ch_addr;
    logic [NUM_CH*XLEN-1:0]      ch_data;
    logic                        flush_W;
    logic [NUM_WP-1:0]           rf_wr_en;
    logic [NUM_WP*TAG_WIDTH-1:0] rf_wr_tag;
    logic [NUM_WP*5-1:0]         rf_wr_addr;
    logic [NUM_WP*XLEN-1:0]      rf_wr_data;
    logic                        clr_dirty_en;
    logic [31:0]                 clr_dirty_mask;

    modport master (
        output ch_valid, ch_tag, ch_addr, ch_data, flush_W,
        input  ch_ready, rf_wr_en, rf_wr_tag, rf_wr_addr, rf_wr_data,
        input  clr_dirty_en, clr_dirty_mask
    );

    modport slave (
        input  ch_valid, ch_tag, ch_addr, ch_data, flush_W,
        output ch_ready, rf_wr_en, rf_wr_tag, rf_wr_addr, rf_wr_data,
        output clr_dirty_en, clr_dirty_mask
    );
endinterface

// File: rtl/wb_multi_port.sv
// Write-back stage: per-channel result queues, round-robin arbitration onto NUM_WP regfile ports.
// Define WB_BYPASS_EN to let an empty channel's incoming result be written in its accept cycle.
module wb_multi_port #(
    parameter int NUM_CH    = 3,
    parameter int NUM_WP    = 1,
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 4,
    parameter int XLEN      = 32
) (
    input logic            clk,
    input logic            reset,
    wb_multi_port_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [TAG_WIDTH-1:0] q_tag  [NUM_CH][DEPTH];
    logic [4:0]           q_addr [NUM_CH][DEPTH];
    logic [XLEN-1:0]      q_data [NUM_CH][DEPTH];
    logic [PW-1:0]        rd_ptr [NUM_CH];
    logic [PW-1:0]        wr_ptr [NUM_CH];
    logic [CW-1:0]        count  [NUM_CH];
    logic [RW-1:0]        rr_ptr;
    logic [RW-1:0]        rr_next;

    logic [TAG_WIDTH-1:0] in_tag  [NUM_CH];
    logic [4:0]           in_addr [NUM_CH];
    logic [XLEN-1:0]      in_data [NUM_CH];
    logic [NUM_CH-1:0]    ready;
    logic [NUM_CH-1:0]    accept;
    logic [NUM_CH-1:0]    push;
    logic [NUM_CH-1:0]    pop;
    logic [NUM_CH-1:0]    bypass;

    logic [NUM_WP-1:0]    wr_en;
    logic [TAG_WIDTH-1:0] wr_tag  [NUM_WP];
    logic [4:0]           wr_addr [NUM_WP];
    logic [XLEN-1:0]      wr_data [NUM_WP];

    logic [TAG_WIDTH-1:0] h_tag;
    logic [4:0]           h_addr;
    logic [XLEN-1:0]      h_data;
    logic                 h_valid;
    logic                 h_clash;
    int                   scan_idx;
    int                   n_grant;
    int                   slot_off;
    logic [31:0]          mask;

    // Ready looks only at the registered count, never at this cycle's pop or grant.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_tag[i]  = bus.ch_tag[i*TAG_WIDTH +: TAG_WIDTH];
            in_addr[i] = bus.ch_addr[i*5 +: 5];
            in_data[i] = bus.ch_data[i*XLEN +: XLEN];
            ready[i]   = !reset && (count[i] < CNT_FULL);
        end
    end

    assign bus.ch_ready = ready;
    assign accept       = bus.ch_valid & ready;

    always_comb begin
        pop      = '0;
        bypass   = '0;
        wr_en    = '0;
        rr_next  = rr_ptr;
        n_grant  = 0;
        scan_idx = 0;
        h_tag    = '0;
        h_addr   = '0;
        h_data   = '0;
        h_valid  = 1'b0;
        h_clash  = 1'b0;
        for (int p = 0; p < NUM_WP; p++) begin
            wr_tag[p]  = '0;
            wr_addr[p] = '0;
            wr_data[p] = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
            h_valid = (count[scan_idx] != '0);
            h_tag   = q_tag[scan_idx][rd_ptr[scan_idx]];
            h_addr  = q_addr[scan_idx][rd_ptr[scan_idx]];
            h_data  = q_data[scan_idx][rd_ptr[scan_idx]];
`ifdef WB_BYPASS_EN
            if (count[scan_idx] == '0) begin
                h_valid = accept[scan_idx] && (in_addr[scan_idx] != 5'd0);
                h_tag   = in_tag[scan_idx];
                h_addr  = in_addr[scan_idx];
                h_data  = in_data[scan_idx];
            end
`endif
            // Two ports must never target the same rd in one cycle; the later head waits.
            h_clash = 1'b0;
            for (int p = 0; p < NUM_WP; p++) begin
                if ((p < n_grant) && (wr_addr[p] == h_addr)) h_clash = 1'b1;
            end
            if (h_valid && !h_clash && (n_grant < NUM_WP) && !reset && !bus.flush_W) begin
                wr_en[n_grant]   = 1'b1;
                wr_tag[n_grant]  = h_tag;
                wr_addr[n_grant] = h_addr;
                wr_data[n_grant] = h_data;
                if (count[scan_idx] != '0) pop[scan_idx] = 1'b1;
                else                       bypass[scan_idx] = 1'b1;
                rr_next = (scan_idx == NUM_CH - 1) ? '0 : RW'(scan_idx + 1);
                n_grant = n_grant + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = accept[i] && (in_addr[i] != 5'd0) && !bypass[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (bus.flush_W) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    q_tag[i][wr_ptr[i]]  <= in_tag[i];
                    q_addr[i][wr_ptr[i]] <= in_addr[i];
                    q_data[i][wr_ptr[i]] <= in_data[i];
                    wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Killed rds: every live slot plus whatever is being accepted in the flush cycle.
    always_comb begin
        mask     = '0;
        slot_off = 0;
        if (bus.flush_W && !reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    slot_off = j - int'(rd_ptr[i]);
                    if (slot_off < 0) slot_off = slot_off + DEPTH;
                    if (slot_off < int'(count[i])) mask = mask | (32'd1 << q_addr[i][j]);
                end
                if (accept[i]) mask = mask | (32'd1 << in_addr[i]);
            end
            mask[0] = 1'b0;
        end
    end

    assign bus.clr_dirty_mask = mask;
    assign bus.clr_dirty_en   = |mask;
    assign bus.rf_wr_en       = wr_en;

    for (genvar k = 0; k < NUM_WP; k++) begin : g_port
        assign bus.rf_wr_tag[k*TAG_WIDTH +: TAG_WIDTH] = wr_tag[k];
        assign bus.rf_wr_addr[k*5 +: 5]                = wr_addr[k];
        assign bus.rf_wr_data[k*XLEN +: XLEN]          = wr_data[k];
    end
endmodule

// File: tb/tb_wb_multi_port.sv
// Scoreboard bench for wb_multi_port: one instance with a single write port, one with two.
// Directed pushes queue expected writes/masks; a negedge monitor pops and compares.
module tb_wb_multi_port;
    localparam int NC = 3;
    localparam int DP = 2;
    localparam int TW = 4;
    localparam int XL = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_multi_port_if #(.NUM_CH(NC), .NUM_WP(1), .TAG_WIDTH(TW), .XLEN(XL)) bus_a ();
    wb_multi_port_if #(.NUM_CH(NC), .NUM_WP(2), .TAG_WIDTH(TW), .XLEN(XL)) bus_b ();

    wb_multi_port #(.NUM_CH(NC), .NUM_WP(1), .DEPTH(DP), .TAG_WIDTH(TW), .XLEN(XL)) u_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    wb_multi_port #(.NUM_CH(NC), .NUM_WP(2), .DEPTH(DP), .TAG_WIDTH(TW), .XLEN(XL)) u_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct packed {
        int            cyc;
        int            port;
        logic [4:0]    addr;
        logic [TW-1:0] tag;
        logic [XL-1:0] data;
    } wr_t;

    typedef struct packed {
        int          cyc;
        logic [31:0] mask;
    } mk_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    mk_t exp_m[$];
    wr_t mon_g;
    mk_t mon_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_write(input int dut, input wr_t g);
        wr_t e;
        logic have;
        have = (dut == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL wr_dut%0d_unexpected actual: cyc=%0d port=%0d addr=%0d required: no write",
                     dut, g.cyc, g.port, g.addr);
        end else begin
            if (dut == 0) e = exp_a.pop_front();
            else          e = exp_b.pop_front();
            if (g !== e) begin
                failures++;
                $display("FAIL wr_dut%0d actual: cyc=%0d port=%0d addr=%0d tag=%0h data=%0h required: cyc=%0d port=%0d addr=%0d tag=%0h data=%0h",
                         dut, g.cyc, g.port, g.addr, g.tag, g.data, e.cyc, e.port, e.addr, e.tag, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.rf_wr_en[0] === 1'b1) begin
            mon_g = '{cyc, 0, bus_a.rf_wr_addr[4:0], bus_a.rf_wr_tag[TW-1:0], bus_a.rf_wr_data[XL-1:0]};
            check_write(0, mon_g);
        end
        for (int k = 0; k < 2; k++) begin
            if (bus_b.rf_wr_en[k] === 1'b1) begin
                mon_g = '{cyc, k, bus_b.rf_wr_addr[k*5 +: 5], bus_b.rf_wr_tag[k*TW +: TW], bus_b.rf_wr_data[k*XL +: XL]};
                check_write(1, mon_g);
            end
        end
        if (bus_a.clr_dirty_en === 1'b1 || bus_a.clr_dirty_mask != 32'd0) begin
            checks++;
            if (exp_m.size() == 0) begin
                failures++;
                $display("FAIL clr_unexpected actual: cyc=%0d en=%0b mask=%0h required: no clear",
                         cyc, bus_a.clr_dirty_en, bus_a.clr_dirty_mask);
            end else begin
                mon_m = exp_m.pop_front();
                if (cyc != mon_m.cyc || bus_a.clr_dirty_mask !== mon_m.mask || bus_a.clr_dirty_en !== 1'b1) begin
                    failures++;
                    $display("FAIL clr_mask actual: cyc=%0d en=%0b mask=%0h required: cyc=%0d en=1 mask=%0h",
                             cyc, bus_a.clr_dirty_en, bus_a.clr_dirty_mask, mon_m.cyc, mon_m.mask);
                end
            end
        end
        if (bus_b.clr_dirty_en !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL clr_b_unexpected actual en=%0b required en=0", bus_b.clr_dirty_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.ch_valid = '0;
        bus_b.ch_valid = '0;
        bus_a.flush_W  = 1'b0;
        bus_b.flush_W  = 1'b0;
    endtask

    task automatic put_a(input int ch, input logic [4:0] a, input logic [31:0] d);
        bus_a.ch_valid[ch]          = 1'b1;
        bus_a.ch_addr[ch*5 +: 5]    = a;
        bus_a.ch_tag[ch*TW +: TW]   = a[TW-1:0];
        bus_a.ch_data[ch*XL +: XL]  = d;
    endtask

    task automatic put_b(input int ch, input logic [4:0] a, input logic [31:0] d);
        bus_b.ch_valid[ch]          = 1'b1;
        bus_b.ch_addr[ch*5 +: 5]    = a;
        bus_b.ch_tag[ch*TW +: TW]   = a[TW-1:0];
        bus_b.ch_data[ch*XL +: XL]  = d;
    endtask

    task automatic exp_w(input int dut, input int c, input int p, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e = '{c, p, a, a[TW-1:0], d};
        if (dut == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
    endtask

    task automatic exp_clr(input int c, input logic [31:0] m);
        mk_t e;
        e = '{c, m};
        exp_m.push_back(e);
    endtask

    initial begin
        bus_a.ch_addr = '0; bus_a.ch_tag = '0; bus_a.ch_data = '0;
        bus_b.ch_addr = '0; bus_b.ch_tag = '0; bus_b.ch_data = '0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("ready_during_reset_a", 64'(bus_a.ch_ready), 64'h0);
        chk("ready_during_reset_b", 64'(bus_b.ch_ready), 64'h0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset_a", 64'(bus_a.ch_ready), 64'h7);
        chk("ready_after_reset_b", 64'(bus_b.ch_ready), 64'h7);

        // Same rd on ch0 and ch1 (two ports): second waits a cycle. rr ends at 2.
        t = cyc;
        put_b(0, 5'd7, 32'h70);
        put_b(1, 5'd7, 32'h71);
        exp_w(1, t + 1, 0, 5'd7, 32'h70);
        exp_w(1, t + 2, 0, 5'd7, 32'h71);
        tick(); idle(); repeat (3) tick();

        // Distinct rds on ch0/ch1: scan starts at ch2 (empty), both written together.
        t = cyc;
        put_b(0, 5'd4, 32'h40);
        put_b(1, 5'd6, 32'h60);
        exp_w(1, t + 1, 0, 5'd4, 32'h40);
        exp_w(1, t + 1, 1, 5'd6, 32'h60);
        tick(); idle(); repeat (3) tick();

        // Three channels at once, one port: rd 1,2,3 on successive cycles, twice.
        for (int r = 0; r < 2; r++) begin
            t = cyc;
            put_a(0, 5'd1, 32'h101 + 32'(r));
            put_a(1, 5'd2, 32'h202 + 32'(r));
            put_a(2, 5'd3, 32'h303 + 32'(r));
            exp_w(0, t + 1, 0, 5'd1, 32'h101 + 32'(r));
            exp_w(0, t + 2, 0, 5'd2, 32'h202 + 32'(r));
            exp_w(0, t + 3, 0, 5'd3, 32'h303 + 32'(r));
            tick(); idle(); repeat (4) tick();
        end

        // Single push lands one cycle later; rr moves to 1.
        t = cyc;
        put_a(0, 5'd5, 32'h11);
        exp_w(0, t + 1, 0, 5'd5, 32'h11);
        tick(); idle(); repeat (2) tick();

        // rd=0 is accepted and dropped.
        put_a(1, 5'd0, 32'h99);
        tick(); idle(); repeat (3) tick();

        // Depth-2 fill on ch2 with rr=1, third push held, FIFO across wrap.
        t = cyc;
        put_a(0, 5'd10, 32'hA0);
        put_a(1, 5'd11, 32'hB0);
        put_a(2, 5'd12, 32'hC0);
        exp_w(0, t + 1, 0, 5'd11, 32'hB0);
        exp_w(0, t + 2, 0, 5'd12, 32'hC0);
        exp_w(0, t + 3, 0, 5'd10, 32'hA0);
        exp_w(0, t + 4, 0, 5'd13, 32'hC1);
        exp_w(0, t + 5, 0, 5'd14, 32'hC2);
        tick();
        bus_a.ch_valid = '0;
        put_a(2, 5'd13, 32'hC1);
        chk("ready2_one_queued", 64'(bus_a.ch_ready[2]), 64'h1);
        tick();
        put_a(2, 5'd14, 32'hC2);
        chk("ready2_full", 64'(bus_a.ch_ready[2]), 64'h0);
        tick();
        chk("ready2_after_pop", 64'(bus_a.ch_ready[2]), 64'h1);
        tick(); idle(); repeat (4) tick();

        // Flush with rd 3 (ch0) and 9 (ch1) queued plus ch2 accepting rd 3.
        t = cyc;
        put_a(0, 5'd3, 32'h33);
        put_a(1, 5'd9, 32'h99);
        tick();
        bus_a.ch_valid = '0;
        put_a(2, 5'd3, 32'h3C);
        bus_a.flush_W = 1'b1;
        exp_clr(t + 1, 32'h208);
        #1;
        chk("flush_wr_en", 64'(bus_a.rf_wr_en), 64'h0);
        tick(); idle();
        chk("ready_after_flush", 64'(bus_a.ch_ready), 64'h7);
        repeat (3) tick();

        // Flush with rd=0 queued and accepted: those never reach the mask.
        t = cyc;
        put_a(0, 5'd0, 32'h1);
        put_a(1, 5'd2, 32'h22);
        tick();
        bus_a.ch_valid = '0;
        put_a(2, 5'd0, 32'h2);
        put_a(0, 5'd6, 32'h66);
        bus_a.flush_W = 1'b1;
        exp_clr(t + 1, 32'h44);
        tick(); idle();
        chk("ready_after_flush2", 64'(bus_a.ch_ready), 64'h7);
        repeat (3) tick();

        // Reset with two entries queued: nothing written, no clear.
        put_a(0, 5'd20, 32'h20);
        put_a(1, 5'd21, 32'h21);
        tick(); idle();
        reset = 1'b1;
        #1;
        chk("reset_wr_en", 64'(bus_a.rf_wr_en), 64'h0);
        chk("reset_ready", 64'(bus_a.ch_ready), 64'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("ready_after_reset_release", 64'(bus_a.ch_ready), 64'h7);
        repeat (5) tick();

        chk("pending_writes_a", 64'(exp_a.size()), 64'h0);
        chk("pending_writes_b", 64'(exp_b.size()), 64'h0);
        chk("pending_clears", 64'(exp_m.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
